// File: rtl/logic_bist_checker.sv
// Exhaustive stimulus/response checker for a 2-input WIDTH-bit bitwise logic unit.
// Optional build macro LOGIC_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module logic_bist_checker #(
    parameter int WIDTH         = 1,
    parameter int OP            = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_c
);

    localparam int VW = 2 * WIDTH;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [VW-1:0] VEC_LAST    = '1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t           r_state;
    logic [VW-1:0]    r_vec;
    logic [SW-1:0]    r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [7:0]       r_err_count;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    logic [WIDTH-1:0] r_fail_c;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_expected;
    logic             w_mismatch;
    logic             w_first;
    logic             w_last;
    logic             w_end;
    logic [7:0]       w_err_next;

    function automatic logic [WIDTH-1:0] expect_fn(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        case (OP)
            1:       return x & y;
            2:       return x | y;
            3:       return ~(x ^ y);
            default: return x ^ y;
        endcase
    endfunction

    assign w_a        = r_vec[VW-1:WIDTH];
    assign w_b        = r_vec[WIDTH-1:0];
    assign w_expected = expect_fn(w_a, w_b);
    assign w_mismatch = (c != w_expected);
    // A zero count means no mismatch yet; saturation never wraps back to zero.
    assign w_first    = (r_err_count == 8'd0);
    assign w_last     = (r_vec == VEC_LAST);
    assign w_err_next = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

`ifdef LOGIC_BIST_STOP_ON_FAIL_EN
    assign w_end = w_last || w_mismatch;
`else
    assign w_end = w_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_settle    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 8'd0;
            r_fail_a    <= '0;
            r_fail_b    <= '0;
            r_fail_c    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= SETTLE;
                        r_vec       <= '0;
                        r_settle    <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_err_count <= 8'd0;
                        r_fail_a    <= '0;
                        r_fail_b    <= '0;
                        r_fail_c    <= '0;
                    end
                end
                SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_err_count <= w_err_next;
                        if (w_first) begin
                            r_fail_a <= w_a;
                            r_fail_b <= w_b;
                            r_fail_c <= c;
                        end
                    end
                    if (w_end) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= w_first && !w_mismatch;
                    end else begin
                        r_state  <= SETTLE;
                        r_vec    <= r_vec + 1'b1;
                        r_settle <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a         = w_a;
    assign b         = w_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;
    assign fail_c    = r_fail_c;

endmodule

// File: tb/tb_logic_bist_checker.sv
// Scoreboard bench: a 1-bit XOR checker and a 4-bit AND checker, each against a faultable unit.
module tb_logic_bist_checker;

`ifdef LOGIC_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start2;
    logic       fault1, fault2;

    logic [0:0] a1, b1, c1, fa1, fb1, fc1;
    logic       busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] a2, b2, c2, fa2, fb2, fc2;
    logic       busy2, done2, pass2;
    logic [7:0] err2;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         lat;
        bit         aborted;
        bit         pass;
        int         errc;
        logic [3:0] ea, eb, fa, fb, fc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign c1 = fault1 ? 1'b0 : (a1 ^ b1);
    assign c2 = (a2 & b2) ^ {3'b000, fault2};

    logic_bist_checker #(.WIDTH(1), .OP(0), .SETTLE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_a(fa1), .fail_b(fb1), .fail_c(fc1)
    );

    logic_bist_checker #(.WIDTH(4), .OP(1), .SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c(c2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_a(fa2), .fail_b(fb2), .fail_c(fc2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic observe(input int which,
                           output logic [3:0] oa, output logic [3:0] ob,
                           output logic [3:0] ofa, output logic [3:0] ofb, output logic [3:0] ofc,
                           output logic obusy, output logic odone, output logic opass,
                           output logic [7:0] oerr);
        if (which == 1) begin
            oa = {3'b000, a1}; ob = {3'b000, b1};
            ofa = {3'b000, fa1}; ofb = {3'b000, fb1}; ofc = {3'b000, fc1};
            obusy = busy1; odone = done1; opass = pass1; oerr = err1;
        end else begin
            oa = a2; ob = b2; ofa = fa2; ofb = fb2; ofc = fc2;
            obusy = busy2; odone = done2; opass = pass2; oerr = err2;
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 1) start1 = v;
        else start2 = v;
    endtask

    function automatic exp_t mk(input int lat, input bit ab, input bit p, input int errc,
                                input logic [3:0] ea, input logic [3:0] eb,
                                input logic [3:0] fa, input logic [3:0] fb, input logic [3:0] fc);
        exp_t e;
        e.lat = lat; e.aborted = ab; e.pass = p; e.errc = errc;
        e.ea = ea; e.eb = eb; e.fa = fa; e.fb = fb; e.fc = fc;
        return e;
    endfunction

    // One run: edge E0 samples start; n counts edges after E0.
    task automatic run(input int which, input logic flt, input int restart_at,
                       input int rst_at, input exp_t e);
        int         w, nvec, n, vec;
        bit         fin;
        exp_t       got;
        logic [3:0] oa, ob, ofa, ofb, ofc, mask;
        logic       obusy, odone, opass;
        logic [7:0] oerr;
        w    = (which == 1) ? 1 : 4;
        nvec = 1 << (2 * w);
        mask = (which == 1) ? 4'h1 : 4'hF;
        if (which == 1) fault1 = flt;
        else fault2 = flt;
        sb.push_back(e);
        @(negedge clk);
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        n = 0;
        observe(which, oa, ob, ofa, ofb, ofc, obusy, odone, opass, oerr);
        check_val("start_busy", obusy, 1'b1);
        check_val("start_done", odone, 1'b0);
        check_val("start_pass", opass, 1'b0);
        check_val("start_err", oerr, 8'd0);
        check_val("start_ab", {oa, ob}, 8'h00);
        check_val("start_fail", {ofa, ofb, ofc}, 12'h000);
        fin = 1'b0;
        while (!fin && n < nvec * 3 + 20) begin
            if (restart_at == n + 1) set_start(which, 1'b1);
            if (rst_at == n + 1) rst = 1'b1;
            @(negedge clk);
            n++;
            set_start(which, 1'b0);
            rst = 1'b0;
            observe(which, oa, ob, ofa, ofb, ofc, obusy, odone, opass, oerr);
            if (rst_at == n || odone) begin
                fin = 1'b1;
            end else begin
                vec = n / 3;
                if (vec > nvec - 1) vec = nvec - 1;
                check_val("run_busy", obusy, 1'b1);
                check_val("run_a", oa, (vec >> w) & mask);
                check_val("run_b", ob, vec & mask);
            end
        end
        if (!fin) check_val("done_timeout", 1'b0, 1'b1);
        got = sb.pop_front();
        if (got.aborted) begin
            check_val("rst_busy", obusy, 1'b0);
            check_val("rst_done", odone, 1'b0);
            check_val("rst_pass", opass, 1'b0);
            check_val("rst_err", oerr, 8'd0);
            check_val("rst_ab", {oa, ob}, 8'h00);
            check_val("rst_fail", {ofa, ofb, ofc}, 12'h000);
        end else begin
            check_val("latency", n, got.lat);
            check_val("end_busy", obusy, 1'b0);
            check_val("end_pass", opass, got.pass);
            check_val("end_err", oerr, got.errc);
            check_val("end_ab", {oa, ob}, {got.ea, got.eb});
            check_val("end_fail", {ofa, ofb, ofc}, {got.fa, got.fb, got.fc});
        end
        @(negedge clk);
        observe(which, oa, ob, ofa, ofb, ofc, obusy, odone, opass, oerr);
        check_val("hold_done", odone, !got.aborted);
        check_val("hold_busy", obusy, 1'b0);
        check_val("hold_err", oerr, got.errc);
        check_val("hold_ab", {oa, ob}, {got.ea, got.eb});
    endtask

    initial begin
        logic [3:0] oa, ob, ofa, ofb, ofc;
        logic       obusy, odone, opass;
        logic [7:0] oerr;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; fault1 = 1'b0; fault2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 1; d <= 2; d++) begin
            observe(d, oa, ob, ofa, ofb, ofc, obusy, odone, opass, oerr);
            check_val("reset_ctrl", {obusy, odone, opass}, 3'b000);
            check_val("reset_err", oerr, 8'd0);
            check_val("reset_ab", {oa, ob}, 8'h00);
            check_val("reset_fail", {ofa, ofb, ofc}, 12'h000);
        end
        rst = 1'b0;

        run(1, 1'b0, -1, -1, mk(12, 0, 1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0));
        run(1, 1'b1, -1, -1, mk(STOP ? 6 : 12, 0, 0, STOP ? 1 : 2,
                                STOP ? 4'h0 : 4'h1, 4'h1, 4'h0, 4'h1, 4'h0));
        // Start pulsed mid-run must be ignored; also checks fail_* were cleared by start.
        run(1, 1'b0, 5, -1, mk(12, 0, 1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0));
        run(1, 1'b0, -1, 7, mk(0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0));
        run(1, 1'b0, -1, -1, mk(12, 0, 1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0));

        run(2, 1'b0, -1, -1, mk(768, 0, 1, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0));
        run(2, 1'b1, -1, -1, mk(STOP ? 3 : 768, 0, 0, STOP ? 1 : 255,
                                STOP ? 4'h0 : 4'hF, STOP ? 4'h0 : 4'hF, 4'h0, 4'h0, 4'h1));

        if (sb.size() != 0) check_val("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
